// File: rtl/mem_bus_ctrl_if.sv
// CPU-side request/ready bus of the memory-bus controller.
// master = CPU, slave = controller.
interface mem_bus_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_wren;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_wren,
        input  cpu_ready, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_wren,
        output cpu_ready, cpu_rdata
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Registered CPU-to-memory access sequencer with per-region wait states.
// Optional write protection: define MEMCTL_WPROT_EN.
module mem_bus_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
`ifdef MEMCTL_WPROT_EN
    parameter logic [NREG-1:0] WPROT = '0,
`endif
    parameter logic [NREG*ADDR_W-1:0] REG_BASE =
        {16'hC000, 16'hE000, 16'hF000, 16'h0000},
    parameter logic [NREG*ADDR_W-1:0] REG_MASK =
        {16'hF000, 16'hF000, 16'hF000, 16'h8000},
    parameter logic [NREG*3-1:0] REG_WAIT =
        {3'd2, 3'd0, 3'd0, 3'd0},
    parameter logic [DATA_W-1:0] FILL = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset_n,
`ifdef MEMCTL_WPROT_EN
    input  logic                   wprot_lock,
`endif
    mem_bus_ctrl_if.slave          cpu,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic [NREG-1:0]        mem_sel,
    output logic [NREG-1:0]        mem_wren,
    input  logic [NREG*DATA_W-1:0] mem_rdata,
    output logic                   fault,
    output logic [ADDR_W-1:0]      fault_addr,
    input  logic                   fault_clr
);
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, LATCH} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     cur, dec_idx;
    logic              dec_hit, blk_dec;
    logic              hit_q, wr_q, blk_q;
    logic [2:0]        wcnt;
    logic              accept, flt_set;
    logic              ready_q;
    logic [DATA_W-1:0] rdata_q;

    assign cpu.cpu_ready = ready_q;
    assign cpu.cpu_rdata = rdata_q;

    // Scan from the top so the lowest matching index is the last one kept.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int k = NREG - 1; k >= 0; k--) begin
            if ((cpu.cpu_addr & REG_MASK[k*ADDR_W +: ADDR_W]) ==
                REG_BASE[k*ADDR_W +: ADDR_W]) begin
                dec_hit = 1'b1;
                dec_idx = IW'(k);
            end
        end
    end

`ifdef MEMCTL_WPROT_EN
    assign blk_dec = dec_hit & cpu.cpu_wren & wprot_lock & WPROT[dec_idx];
`else
    assign blk_dec = 1'b0;
`endif

    assign flt_set = (state == LATCH) && (!hit_q || blk_q);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Strobes are gated by reset_n so an aborted access never writes.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        mem_sel  = '0;
        mem_wren = '0;
        unique case (state)
            IDLE: begin
                if (cpu.cpu_req) begin
                    accept   = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (hit_q) mem_sel[cur] = reset_n;
                if (wcnt == 3'd0) begin
                    state_nx = LATCH;
                    if (hit_q && wr_q && !blk_q) mem_wren[cur] = reset_n;
                end
            end
            LATCH: begin
                if (hit_q) mem_sel[cur] = reset_n;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cur        <= '0;
            hit_q      <= 1'b0;
            wr_q       <= 1'b0;
            blk_q      <= 1'b0;
            wcnt       <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            ready_q <= (state == LATCH);
            if (accept) begin
                mem_addr  <= cpu.cpu_addr;
                mem_wdata <= cpu.cpu_wdata;
                wr_q      <= cpu.cpu_wren;
                hit_q     <= dec_hit;
                cur       <= dec_idx;
                blk_q     <= blk_dec;
                wcnt      <= dec_hit ? REG_WAIT[dec_idx*3 +: 3] : 3'd0;
            end else if (state == ACCESS && wcnt != 3'd0) begin
                wcnt <= wcnt - 3'd1;
            end
            if (state == LATCH && !wr_q)
                rdata_q <= hit_q ? mem_rdata[cur*DATA_W +: DATA_W] : FILL;
            // A fault in the same cycle as a clear wins and re-captures.
            if (flt_set) begin
                fault <= 1'b1;
                if (!fault || fault_clr) fault_addr <= mem_addr;
            end else if (fault_clr) begin
                fault <= 1'b0;
            end
        end
    end
endmodule
